// File: rtl/fifo_serial_pkg.sv
// rtl/fifo_serial_pkg.sv - shared FSM state type and line-level constants for fifo_serial_tx
package fifo_serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/fifo_serial_tx_if.sv
// rtl/fifo_serial_tx_if.sv - FIFO read side, tx enable and serial status bundle
interface fifo_serial_tx_if #(
  parameter int WIDTH = 8
);
  import fifo_serial_pkg::*;

  logic                   fifo_empty;
  logic                   fifo_rd_en;
  logic [WIDTH-1:0]       fifo_r_data;
  logic                   tx_en;
  logic                   tx_line;
  logic                   busy;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  // Driver side: owns the FIFO flags/data and the enable
  modport master (
    output fifo_empty, fifo_r_data, tx_en,
    input  fifo_rd_en, tx_line, busy, frame_cnt
  );

  // Transmitter side
  modport slave (
    input  fifo_empty, fifo_r_data, tx_en,
    output fifo_rd_en, tx_line, busy, frame_cnt
  );

endinterface

// File: rtl/fifo_serial_tx_bit_timer.sv
// rtl/fifo_serial_tx_bit_timer.sv - CLKS_PER_BIT cycle counter with end-of-bit pulse
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_done = run && (cnt_q == CW'(CLKS_PER_BIT - 1));

  // Count while a bit is on the line; restart at every bit boundary and when idle
  always_comb begin
    cnt_d = '0;
    if (run && !bit_done) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// rtl/fifo_serial_tx.sv - FIFO-draining serial transmitter; FIFO_SERIAL_TX_PARITY_EN adds even parity
module fifo_serial_tx
  import fifo_serial_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input logic             clk,
  input logic             rst,
  fifo_serial_tx_if.slave bus
);
  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       shift_q, shift_d;
  logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                   tx_line_q, tx_line_d;
  logic                   rd_en_q, rd_en_d;
  logic                   busy_q, busy_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  logic timer_run;
  logic bit_done;
  logic can_pop;
  logic last_bit;

  assign timer_run = (state_q == START) || (state_q == DATA) ||
                     (state_q == PARITY) || (state_q == STOP);
  assign can_pop   = bus.tx_en && !bus.fifo_empty;
  assign last_bit  = (bit_cnt_q == BCW'(WIDTH - 1));

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (timer_run),
    .bit_done (bit_done)
  );

  // Next state and next registered outputs; tx_line_d is the level of the state being entered
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    tx_line_d   = tx_line_q;
    rd_en_d     = 1'b0;
    busy_d      = busy_q;
    frame_cnt_d = frame_cnt_q;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_line_d = IDLE_LEVEL;
        busy_d    = 1'b0;
        if (can_pop) begin
          state_d = POP;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      POP: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d   = bus.fifo_r_data;
        bit_cnt_d = '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
        parity_d  = ^bus.fifo_r_data;
`endif
        state_d   = START;
        tx_line_d = START_LEVEL;
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          tx_line_d = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (last_bit) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
            state_d   = PARITY;
            tx_line_d = parity_q;
`else
            state_d   = STOP;
            tx_line_d = STOP_LEVEL;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
            tx_line_d = shift_d[0];
          end
        end
      end
`ifdef FIFO_SERIAL_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d   = STOP;
          tx_line_d = STOP_LEVEL;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
          tx_line_d   = IDLE_LEVEL;
          if (can_pop) begin
            state_d = POP;
            rd_en_d = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        tx_line_d = IDLE_LEVEL;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      tx_line_q   <= IDLE_LEVEL;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_line_q   <= tx_line_d;
      rd_en_q     <= rd_en_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign bus.tx_line    = tx_line_q;
  assign bus.fifo_rd_en = rd_en_q;
  assign bus.busy       = busy_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb/tb_fifo_serial_tx.sv - directed bench for fifo_serial_tx with a depth-16 sync FIFO model
module tb_fifo_serial_tx;

`ifdef FIFO_SERIAL_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FCYC = NB * 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_en = 1'b0;
  logic wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic fifo_clr = 1'b1;

  int tests_run = 0;
  int tests_failed = 0;

  fifo_serial_tx_if #(.WIDTH(8)) bus ();

  fifo_serial_tx #(
    .WIDTH(8),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // sync FIFO, depth 16, read latency 1
  logic [7:0] mem [16];
  logic [3:0] wp, rp;
  int fifo_count;
  logic [7:0] fifo_rdata;
  logic rd_err;

  assign bus.fifo_empty  = (fifo_count == 0);
  assign bus.fifo_r_data = fifo_rdata;
  assign bus.tx_en       = tx_en;

  always @(posedge clk) begin
    if (fifo_clr) begin
      wp <= '0; rp <= '0; fifo_count <= 0; rd_err <= 1'b0; fifo_rdata <= '0;
    end else begin
      if (wr_en && fifo_count < 16) begin
        mem[wp] <= wr_data;
        wp <= wp + 4'd1;
      end
      if (bus.fifo_rd_en) begin
        if (fifo_count == 0) rd_err <= 1'b1;
        else begin
          fifo_rdata <= mem[rp];
          rp <= rp + 4'd1;
        end
      end
      fifo_count <= fifo_count + ((wr_en && fifo_count < 16) ? 1 : 0)
                               - ((bus.fifo_rd_en && fifo_count > 0) ? 1 : 0);
    end
  end

  // serial decoder and activity counters, sampled just after each rising edge
  logic dec_active = 1'b0;
  int dec_pos;
  logic dec_bits [NB];
  logic [7:0] dec_q [$];
  int frame_err = 0;
  int rd_pulses = 0;
  int busy_cycles = 0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      dec_active = 1'b0;
    end else if (!dec_active) begin
      if (bus.tx_line === 1'b0) begin
        dec_active = 1'b1;
        dec_pos = 0;
        dec_bits[0] = 1'b0;
      end
    end else begin
      dec_pos++;
      if (dec_pos % 4 == 0) dec_bits[dec_pos/4] = bus.tx_line;
      else if (bus.tx_line !== dec_bits[dec_pos/4]) frame_err++;
      if (dec_pos == FCYC - 1) begin
        logic [7:0] d;
        for (int j = 0; j < 8; j++) d[j] = dec_bits[1+j];
        if (dec_bits[0] !== 1'b0 || dec_bits[NB-1] !== 1'b1) frame_err++;
`ifdef FIFO_SERIAL_TX_PARITY_EN
        if (dec_bits[9] !== ^d) frame_err++;
`endif
        dec_q.push_back(d);
        dec_active = 1'b0;
      end
    end
    if (!rst && bus.fifo_rd_en === 1'b1) rd_pulses++;
    if (!rst && bus.busy === 1'b1) busy_cycles++;
  end

  task automatic reset_all();
    rst = 1'b1; fifo_clr = 1'b1; tx_en = 1'b0; wr_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; fifo_clr = 1'b0;
    rd_pulses = 0; busy_cycles = 0; frame_err = 0;
    dec_q.delete();
  endtask

  task automatic push_word(input logic [7:0] w);
    wr_data = w; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.tx_line === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_en = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++; if (bus.tx_line !== 1'b1) begin tests_failed++; $display("FAIL reset_tx_line: got %b expected 1", bus.tx_line); end
    tests_run++; if (bus.fifo_rd_en !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_en: got %b expected 0", bus.fifo_rd_en); end
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    tests_run++; if (bus.frame_cnt !== 16'h0000) begin tests_failed++; $display("FAIL reset_frame_cnt: got %0h expected 0", bus.frame_cnt); end
  endtask

  task automatic test_single_frame();
    logic exp_seq [NB];
    int bad = 0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif
    reset_all();
    push_word(8'hA5);
    tx_en = 1'b1;
    @(negedge clk);
    tests_run++; if (bus.fifo_rd_en !== 1'b1 || bus.busy !== 1'b1 || bus.tx_line !== 1'b1)
      begin tests_failed++; $display("FAIL single_pop_cycle: rd_en=%b busy=%b tx=%b expected 1,1,1", bus.fifo_rd_en, bus.busy, bus.tx_line); end
    @(negedge clk);
    tests_run++; if (bus.fifo_rd_en !== 1'b0 || bus.tx_line !== 1'b1)
      begin tests_failed++; $display("FAIL single_load_cycle: rd_en=%b tx=%b expected 0,1", bus.fifo_rd_en, bus.tx_line); end
    @(negedge clk);
    tests_run++; if (bus.tx_line !== 1'b0) begin tests_failed++; $display("FAIL single_latency: tx=%b expected 0 three cycles after enable", bus.tx_line); end
    for (int k = 0; k < FCYC; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.tx_line !== exp_seq[k/4]) bad++;
    end
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL single_sequence: %0d wrong cycles expected 0", bad); end
    tests_run++; if (bus.busy !== 1'b1 || bus.frame_cnt !== 16'd0)
      begin tests_failed++; $display("FAIL single_last_stop: busy=%b cnt=%0d expected 1,0", bus.busy, bus.frame_cnt); end
    @(negedge clk);
    tests_run++; if (bus.frame_cnt !== 16'd1) begin tests_failed++; $display("FAIL single_frame_cnt: got %0d expected 1", bus.frame_cnt); end
    tests_run++; if (bus.busy !== 1'b0 || bus.tx_line !== 1'b1)
      begin tests_failed++; $display("FAIL single_after: busy=%b tx=%b expected 0,1", bus.busy, bus.tx_line); end
    tests_run++; if (dec_q.size() != 1 || dec_q[0] !== 8'hA5 || frame_err != 0)
      begin tests_failed++; $display("FAIL single_decode: n=%0d err=%0d expected 1 frame A5", dec_q.size(), frame_err); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [16];
    int bad = 0;
    int waited = 0;
    reset_all();
    for (int i = 0; i < 16; i++) begin
      words[i] = 8'(i * 29 + 3);
      push_word(words[i]);
    end
    tests_run++; if (fifo_count != 16) begin tests_failed++; $display("FAIL b2b_fifo_full: got %0d expected 16", fifo_count); end
    rd_pulses = 0; busy_cycles = 0;
    tx_en = 1'b1;
    while (dec_q.size() < 16 && waited < 16 * (FCYC + 2) + 200) begin @(negedge clk); waited++; end
    repeat (3) @(negedge clk);
    tests_run++; if (dec_q.size() != 16) begin tests_failed++; $display("FAIL b2b_frames: got %0d expected 16", dec_q.size()); end
    for (int i = 0; i < 16 && i < dec_q.size(); i++) if (dec_q[i] !== words[i]) bad++;
    tests_run++; if (bad != 0 || frame_err != 0) begin tests_failed++; $display("FAIL b2b_data: %0d bad words %0d frame errors expected 0", bad, frame_err); end
    tests_run++; if (rd_pulses != 16) begin tests_failed++; $display("FAIL b2b_rd_pulses: got %0d expected 16", rd_pulses); end
    tests_run++; if (bus.frame_cnt !== 16'd16) begin tests_failed++; $display("FAIL b2b_frame_cnt: got %0d expected 16", bus.frame_cnt); end
    tests_run++; if (fifo_count != 0 || rd_err !== 1'b0) begin tests_failed++; $display("FAIL b2b_fifo_end: count=%0d rd_err=%b expected 0,0", fifo_count, rd_err); end
    tests_run++; if (busy_cycles != 16 * (FCYC + 2)) begin tests_failed++; $display("FAIL b2b_no_gap: busy %0d cycles expected %0d", busy_cycles, 16 * (FCYC + 2)); end
  endtask

  task automatic test_empty_guard();
    int bad = 0;
    reset_all();
    tx_en = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (bus.fifo_rd_en !== 1'b0 || bus.tx_line !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    tests_run++; if (bad != 0 || rd_err !== 1'b0) begin tests_failed++; $display("FAIL empty_guard: %0d bad cycles rd_err=%b expected 0,0", bad, rd_err); end
  endtask

  task automatic test_tx_en_drop();
    bit ok;
    int bad = 0;
    reset_all();
    push_word(8'h5A);
    push_word(8'h81);
    tx_en = 1'b1;
    wait_start(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL drop_start: no start bit seen expected one"); end
    repeat (17) @(negedge clk);
    tx_en = 1'b0;
    repeat (FCYC - 1 - 17) @(negedge clk);
    tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL drop_last_stop_busy: got %b expected 1", bus.busy); end
    @(negedge clk);
    tests_run++; if (bus.busy !== 1'b0 || bus.frame_cnt !== 16'd1)
      begin tests_failed++; $display("FAIL drop_end: busy=%b cnt=%0d expected 0,1", bus.busy, bus.frame_cnt); end
    repeat (50) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.fifo_rd_en !== 1'b0) bad++;
    end
    tests_run++; if (bad != 0 || rd_pulses != 1 || fifo_count != 1)
      begin tests_failed++; $display("FAIL drop_no_second_pop: bad=%0d pops=%0d left=%0d expected 0,1,1", bad, rd_pulses, fifo_count); end
    tests_run++; if (dec_q.size() != 1 || dec_q[0] !== 8'h5A || frame_err != 0)
      begin tests_failed++; $display("FAIL drop_decode: n=%0d err=%0d expected 1 frame 5A", dec_q.size(), frame_err); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int waited = 0;
    reset_all();
    push_word(8'h3C);
    push_word(8'hC3);
    tx_en = 1'b1;
    wait_start(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL midrst_start: no start bit seen expected one"); end
    repeat (25) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++; if (bus.tx_line !== 1'b1 || bus.busy !== 1'b0 || bus.frame_cnt !== 16'd0)
      begin tests_failed++; $display("FAIL midrst_abort: tx=%b busy=%b cnt=%0d expected 1,0,0", bus.tx_line, bus.busy, bus.frame_cnt); end
    rst = 1'b0;
    while (dec_q.size() < 1 && waited < 300) begin @(negedge clk); waited++; end
    repeat (2) @(negedge clk);
    tests_run++; if (dec_q.size() != 1 || dec_q[0] !== 8'hC3 || frame_err != 0)
      begin tests_failed++; $display("FAIL midrst_next_word: n=%0d err=%0d expected 1 frame C3", dec_q.size(), frame_err); end
    tests_run++; if (bus.frame_cnt !== 16'd1 || fifo_count != 0 || rd_err !== 1'b0)
      begin tests_failed++; $display("FAIL midrst_counts: cnt=%0d left=%0d rd_err=%b expected 1,0,0", bus.frame_cnt, fifo_count, rd_err); end
  endtask

  task automatic test_concurrent();
    logic [7:0] exp_q [$];
    int bad = 0;
    int waited = 0;
    bit stuck = 1'b0;
    reset_all();
    tx_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [7:0] w;
      int guard = 0;
      repeat ($urandom_range(1, 5)) @(negedge clk);
      while (fifo_count >= 16 && guard < 1000) begin @(negedge clk); guard++; end
      if (guard >= 1000) stuck = 1'b1;
      w = 8'($urandom_range(0, 255));
      exp_q.push_back(w);
      push_word(w);
    end
    while (dec_q.size() < 200 && waited < 2000) begin @(negedge clk); waited++; end
    repeat (3) @(negedge clk);
    tests_run++; if (stuck || dec_q.size() != 200) begin tests_failed++; $display("FAIL conc_frames: got %0d stuck=%b expected 200,0", dec_q.size(), stuck); end
    for (int i = 0; i < 200 && i < dec_q.size(); i++) if (dec_q[i] !== exp_q[i]) bad++;
    tests_run++; if (bad != 0 || frame_err != 0) begin tests_failed++; $display("FAIL conc_order: %0d bad words %0d frame errors expected 0", bad, frame_err); end
    tests_run++; if (bus.frame_cnt !== 16'd200 || rd_pulses != 200 || rd_err !== 1'b0)
      begin tests_failed++; $display("FAIL conc_counts: cnt=%0d pops=%0d rd_err=%b expected 200,200,0", bus.frame_cnt, rd_pulses, rd_err); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_empty_guard();
    test_tx_en_drop();
    test_reset_mid_frame();
    test_concurrent();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fifo_serial_tx.md
FIFO_SERIAL_TX -- requirements
Module: fifo_serial_tx

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 8, data bits per FIFO word and per serial frame.
- CLKS_PER_BIT, 4, clk cycles each serial bit is held; legal range 2..1023.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, the single clock; all logic on its rising edge.
- rst, input, 1, synchronous active-high reset.
- fifo_empty, input, 1, empty flag from the upstream sync FIFO.
- fifo_rd_en, output, 1, pop strobe to the FIFO.
- fifo_r_data, input, WIDTH, FIFO read data.
- tx_en, input, 1, when low, no new frame starts; a frame already in progress completes.
- tx_line, output, 1, serial output; idles high.
- busy, output, 1, high from the pop cycle through the last stop-bit cycle.
- frame_cnt, output, 16, count of completed frames; wraps 0xFFFF->0x0000.

Function
REQ-003 The block SHALL be the downstream consumer of the sync FIFO.
- It pops one word at a time and transmits it LSB-first: start bit (0), WIDTH data bits, optional parity, stop bit (1).
REQ-004 FSM states SHALL be IDLE, POP, LOAD, START, DATA, PARITY, STOP.
REQ-005 IDLE->POP SHALL occur when tx_en=1 and fifo_empty=0.
- fifo_rd_en is high for exactly the one POP cycle.
REQ-006 fifo_r_data SHALL be valid the cycle after fifo_rd_en (FIFO read latency 1).
- LOAD captures it into the shift register, then goes to START.
REQ-007 Bit timing:
- START, each DATA bit, PARITY and STOP SHALL each drive tx_line for exactly CLKS_PER_BIT cycles.
- A bit counter (0..WIDTH-1) selects the next data bit; data shifts right once per bit.
REQ-008 DATA->PARITY (parity configured in) or DATA->STOP SHALL occur after bit WIDTH-1 completes.
REQ-009 STOP completion:
- frame_cnt increments by 1.
- Next state is POP if tx_en=1 and fifo_empty=0 (back-to-back frames, no idle bit), otherwise IDLE.
REQ-010 tx_line SHALL be registered and equal 1 in IDLE, POP and LOAD.
REQ-011 fifo_rd_en SHALL never assert while fifo_empty=1.
- The block never causes a FIFO underflow (rd_err).
REQ-012 tx_en deassertion mid-frame SHALL NOT truncate the frame; it only blocks the next POP.
REQ-013 Latency: first start-bit cycle SHALL be exactly 3 cycles after the cycle in which IDLE sees tx_en=1 and fifo_empty=0.

Reset
REQ-014 rst=1 at a clock edge SHALL force, on that edge:
- state=IDLE, tx_line=1, fifo_rd_en=0, busy=0, frame_cnt=0, counters=0, shift register=0.
REQ-015 Reset mid-frame SHALL abort the frame immediately with no completion increment.
- The popped word is lost.

Configuration
REQ-016 Macro FIFO_SERIAL_TX_PARITY_EN:
- Defined: the PARITY state sends the even-parity bit (XOR of data bits), so a frame is WIDTH+3 bits.
- Undefined: the PARITY state and logic are absent, so a frame is WIDTH+2 bits.

Structure
REQ-017 Shared package fifo_serial_pkg SHALL hold:
- the FSM state enum typedef;
- localparam IDLE_LEVEL=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1;
- the frame_cnt width constant (16).
REQ-018 One sub-module, bit_timer, SHALL generate the CLKS_PER_BIT cycle counter and bit_done pulse.
- Its counter width is $clog2(CLKS_PER_BIT).

Verification (WIDTH=8, CLKS_PER_BIT=4, FIFO DEPTH=16)
REQ-019 Single frame: write 0xA5 to the FIFO, tx_en=1.
- tx_line sequence is 0,1,0,1,0,0,1,0,1,(parity 0 if EN),1, each bit 4 cycles.
- 40 cycles without parity / 44 with parity; then frame_cnt=1.
REQ-020 Back-to-back: write 16 words (FIFO full).
- 16 frames with no idle gap.
- Exactly 16 fifo_rd_en pulses.
- frame_cnt=16; FIFO empty; rd_err never asserted.
REQ-021 Empty guard: tx_en=1 with an empty FIFO for 100 cycles.
- fifo_rd_en=0, tx_line=1, busy=0 throughout.
REQ-022 tx_en drop: deassert tx_en during DATA bit 3 of frame 1 with 2 words queued.
- Frame 1 completes; no second pop; busy falls after the stop bit.
REQ-023 Reset mid-frame: assert rst during DATA bit 5.
- Next cycle tx_line=1, busy=0, frame_cnt=0.
- After release, the remaining queued word transmits normally.
REQ-024 Concurrent writes: random FIFO writes (1-5 cycle gaps) for 200 words, tx_en=1.
- Serial decode matches the write order exactly; frame_cnt=200.
